// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and frame-layout constants for spi_reg_bank
package spi_reg_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  localparam int RW_BITS     = 1;
  localparam int ADDR_OFFSET = 1;  // address field follows the R/W bit
  localparam int ERR_CNT_W   = 8;

  function automatic int frame_len(input int addr_w, input int data_w);
    return RW_BITS + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop pin synchroniser with rise/fall pulses
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - oversampled SPI register bank with readback and write strobes
// Optional SPI_REG_ERR_CNT_EN: saturating frame-error counter at address NUM_REGS.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                CPOL        = 0,
  parameter int                CPHA        = 0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sclk,
  input  logic                         spi_cs_n,
  input  logic                         spi_copi,
  output logic                         spi_cipo,
  output logic                         spi_cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int                FRAME_LEN  = frame_len(ADDR_W, DATA_W);
  localparam int                CNT_W      = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(ADDR_OFFSET + ADDR_W - 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic unused_sclk_lvl, sclk_rise, sclk_fall;
  logic unused_cs_lvl, cs_rise, cs_fall;
  logic copi_lvl, unused_copi_rise, unused_copi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(CPOL != 0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin_i(spi_sclk),
    .level_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .pin_i(spi_cs_n),
    .level_o(unused_cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .pin_i(spi_copi),
    .level_o(copi_lvl), .rise_o(unused_copi_rise), .fall_o(unused_copi_fall));

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   data_q, tx_q;
  logic                tx_on_q, entry_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_q;
  logic                frame_err_q;

  logic [ADDR_W:0]     cmd_shift;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_val;
  logic                cnt_addr;

  assign cmd_shift = {addr_q, copi_lvl};
  assign rd_addr   = cmd_shift[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD:     if (sample_edge && bit_cnt_q == CMD_LAST) state_d = DATA;
        DATA:    if (sample_edge && bit_cnt_q == FRAME_LAST) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    spi_cipo_oe = (state_q != IDLE);
    spi_cipo    = (state_q == DATA) && !rw_q && tx_on_q && tx_q[DATA_W-1];
  end

`ifdef SPI_REG_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  assign cnt_addr = (addr_q == NUM_REGS_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (entry_q && rw_q && cnt_addr) begin
      err_cnt_q <= '0;
    end else if (frame_err_q && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end
`else
  assign cnt_addr = 1'b0;
`endif

  // Out-of-range addresses read back as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_val = regs_q[i];
    end
`ifdef SPI_REG_ERR_CNT_EN
    if (rd_addr == NUM_REGS_A) rd_val = DATA_W'(err_cnt_q);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      tx_q        <= '0;
      tx_on_q     <= 1'b0;
      entry_q     <= 1'b0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      entry_q     <= (state_q == DATA) && (state_d == DONE);
      if (state_q == IDLE && cs_fall) begin
        bit_cnt_q <= '0;
        tx_on_q   <= 1'b0;
      end
      if (!cs_rise && sample_edge && (state_q == CMD || state_q == DATA))
        bit_cnt_q <= bit_cnt_q + 1'b1;
      if (!cs_rise && state_q == CMD && sample_edge) begin
        addr_q <= cmd_shift[ADDR_W-1:0];
        if (bit_cnt_q == CMD_LAST) begin
          rw_q <= cmd_shift[ADDR_W];
          tx_q <= rd_val;
        end
      end
      // First shift edge in DATA presents the MSB; later ones advance it.
      if (!cs_rise && state_q == DATA) begin
        if (sample_edge) data_q <= {data_q[DATA_W-2:0], copi_lvl};
        if (shift_edge && !rw_q) begin
          if (tx_on_q) tx_q <= tx_q << 1;
          tx_on_q <= 1'b1;
        end
      end
      if (cs_rise && (state_q == CMD || (state_q == DATA && rw_q)))
        frame_err_q <= 1'b1;
      if (entry_q && rw_q) begin
        if (addr_q < NUM_REGS_A) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
              regs_q[i]      <= data_q;
              wr_strobe_q[i] <= 1'b1;
            end
          end
        end else if (!cnt_addr) begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised SPI register-bank peripheral, successor to the fixed 5 x 8-bit write-only SPI config block. It supports configurable register count and data/address width, all four SPI modes, and register readback on CIPO. It sits between the chip pins and the PWM/output-enable logic, oversampling the SPI pins with the system clock. Writes commit on frame completion and produce a per-register strobe.

Parameters:
NUM_REGS, 5, number of data registers (1..2^ADDR_W-1)
DATA_W, 8, register/data-field width in bits
ADDR_W, 7, address-field width in bits
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
SYNC_STAGES, 2, flops in each pin synchroniser (>=2)
RESET_VAL, 0, reset value of every register (DATA_W bits)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
spi_sclk  in  1  SPI clock pin (async)
spi_cs_n  in  1  chip select pin, active-low (async)
spi_copi  in  1  controller-out data pin (async)
spi_cipo  out  1  peripheral-out data
spi_cipo_oe  out  1  CIPO output enable
regs_flat  out  NUM_REGS*DATA_W  register contents, reg i at [i*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-cycle pulse on a committed write to reg i
frame_err  out  1  one-cycle pulse on an aborted frame or a bad address

Behaviour:
- Reset (async on rst high): regs = RESET_VAL; wr_strobe = 0; frame_err = 0; spi_cipo = 0; spi_cipo_oe = 0; state = IDLE; shift/bit counters = 0.
- Pins pass through SYNC_STAGES flops. Edges are detected on the last two synchronised samples. Supported SCLK frequency is at most clk/8.
- Frame is F = 1+ADDR_W+DATA_W bits, MSB first: bit0 = R/W (1 = write), then address, then data.
- Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1; the other edge is the shift edge. The leading edge is the transition away from CPOL.
- State machine:
  - IDLE -> CMD on synced CS_n falling; counters cleared.
  - CMD: shift COPI on sample edges. After 1+ADDR_W bits -> DATA. On a read, latch reg[addr] into the tx shifter (0 if addr >= NUM_REGS).
  - DATA: write frames shift in DATA_W bits. Read frames drive tx MSB on the first shift edge after CMD and shift left on each later shift edge. After the DATA_W-th sample edge -> DONE.
  - DONE: commit on the entry cycle. Further SCLK edges are ignored; stay until CS_n rises.
  - Any state -> IDLE on synced CS_n rising.
- Commit (write, addr < NUM_REGS): reg[addr] <= data, and wr_strobe[addr] = 1 for exactly that cycle. Visible SYNC_STAGES+2 clk after the final sample edge at the pin.
- Write to addr >= NUM_REGS: no register change, frame_err pulses at commit.
- CS_n rising before bit F: frame discarded, no register change, frame_err pulses once. A read is not an error if CS_n rises after at least 1+ADDR_W bits.
- spi_cipo_oe = 1 while state is not IDLE. spi_cipo = 0 outside read DATA.
- Reads never modify registers. Back-to-back frames need CS_n high for at least SYNC_STAGES+2 clk.

Optional Feature:
SPI_REG_ERR_CNT_EN
- Defined: an 8-bit saturating counter increments on every frame_err pulse. It is readable at address NUM_REGS, and a write to that address clears it (no frame_err). Requires NUM_REGS < 2^ADDR_W-1.
- Undefined: no counter; address NUM_REGS behaves as any invalid address.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum {IDLE, CMD, DATA, DONE};
  - frame-field offset constants;
  - a function computing frame length from ADDR_W/DATA_W;
  - ERR_CNT_W = 8.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. It is instantiated for SCLK, CS_n and COPI (COPI uses level only).

Test Plan:
- Defaults, mode 0: write addr 0x04 data 0x80 -> regs[4] = 0x80, wr_strobe = 5'b10000 for 1 clk, frame_err = 0.
- Write addr 0x02 data 0xA5, then read addr 0x02 -> CIPO bits sampled by controller = 1010_0101; regs unchanged; oe high only while CS_n is low.
- CPOL=1, CPHA=1, DATA_W=16, NUM_REGS=8: write addr 7 data 0xBEEF then read -> 0xBEEF on CIPO.
- CS_n rises after 10 bits of a write to addr 1 -> regs[1] unchanged, one frame_err pulse; next full frame commits normally.
- Write addr 0x10 data 0xFF -> no register change, frame_err pulse; read addr 0x10 -> CIPO all zeros.
- rst asserted mid-DATA of a write -> all regs = RESET_VAL immediately, state IDLE; subsequent frame writes correctly. With SPI_REG_ERR_CNT_EN: three error frames then read addr 5 -> 0x03; write addr 5 -> counter 0.
